// File: rtl/permutation_ctrl_pkg.sv
// Shared types and constants for the ASCON permutation sequencer.
// Round numbering follows the 12-round p^a schedule (0..11).
package permutation_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FIRST,
      RUN,
      DONE
   } type_perm_fsm;

   localparam int NB_ROUNDS_MAX = 12;

   localparam logic [3:0] ROUND_FIRST_PA = 4'd0;
   localparam logic [3:0] ROUND_FIRST_PB = 4'd6;
   localparam logic [3:0] ROUND_LAST     = 4'd11;

endpackage

// File: rtl/permutation_ctrl.sv
// Moore sequencer for the ASCON permutation datapath: runs p^a or p^b.
// Outputs decode only from the registered state and round counter.
import permutation_ctrl_pkg::*;

module permutation_ctrl #(
   parameter int ROUND_W     = 4,
   parameter int NB_ROUNDS_A = 12,
   parameter int NB_ROUNDS_B = 6
) (
   input  logic               clock_i,
   input  logic               resetb_i,
   input  logic               start_i,
   input  logic               mode_i,
   output logic [ROUND_W-1:0] round_o,
   output logic               data_sel_o,
   output logic               en_reg_state_o,
   output logic               busy_o,
   output logic               done_o
);

   // Both schedules end on the same last round, so the start index
   // is the shortfall from the full 12-round schedule.
   localparam logic [ROUND_W-1:0] LOAD_A =
      ROUND_W'(NB_ROUNDS_MAX - NB_ROUNDS_A);
   localparam logic [ROUND_W-1:0] LOAD_B =
      ROUND_W'(NB_ROUNDS_MAX - NB_ROUNDS_B);
   localparam logic [ROUND_W-1:0] LAST =
      ROUND_W'(ROUND_LAST);

   type_perm_fsm       state_q;
   type_perm_fsm       state_d;
   logic [ROUND_W-1:0] round_q;
   logic [ROUND_W-1:0] round_d;
   logic [ROUND_W-1:0] load_val;

   // Start index chosen by the mode sampled alongside start.
   assign load_val = mode_i ? LOAD_B : LOAD_A;

   // State and round counter registers with asynchronous clear.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q <= IDLE;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
      end
   end

   // Next-state, counter update and Moore output decode.
   always_comb begin
      state_d        = state_q;
      round_d        = round_q;
      data_sel_o     = 1'b0;
      en_reg_state_o = 1'b0;
      busy_o         = 1'b0;
      done_o         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               round_d = load_val;
               state_d = FIRST;
            end
         end
         FIRST: begin
            en_reg_state_o = 1'b1;
            busy_o         = 1'b1;
            round_d        = round_q + 1'b1;
            state_d        = RUN;
         end
         RUN: begin
            data_sel_o     = 1'b1;
            en_reg_state_o = 1'b1;
            busy_o         = 1'b1;
            if (round_q == LAST) begin
               state_d = DONE;
            end else begin
               round_d = round_q + 1'b1;
            end
         end
         DONE: begin
            data_sel_o = 1'b1;
            busy_o     = 1'b1;
            done_o     = 1'b1;
            if (start_i) begin
               round_d = load_val;
               state_d = FIRST;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   assign round_o = round_q;

endmodule

// File: tb/tb_permutation_ctrl.sv
// Scoreboard bench for permutation_ctrl: expected per-cycle output
// records are queued when a run is started and popped each cycle.
module tb_permutation_ctrl;

   typedef struct packed {
      logic [3:0] rnd;
      logic       sel;
      logic       en;
      logic       busy;
      logic       done;
   } exp_t;

   logic       clock_i;
   logic       resetb_i;
   logic       start_i;
   logic       mode_i;
   logic [3:0] round_o;
   logic       data_sel_o;
   logic       en_reg_state_o;
   logic       busy_o;
   logic       done_o;

   exp_t       sb_q[$];
   logic [3:0] idle_round;
   int         n_checks;
   int         n_errors;
   int         cyc;
   int         t0;
   int         en_cnt;
   int         done_cnt;

   permutation_ctrl #(
      .ROUND_W    (4),
      .NB_ROUNDS_A(12),
      .NB_ROUNDS_B(6)
   ) dut (
      .clock_i       (clock_i),
      .resetb_i      (resetb_i),
      .start_i       (start_i),
      .mode_i        (mode_i),
      .round_o       (round_o),
      .data_sel_o    (data_sel_o),
      .en_reg_state_o(en_reg_state_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t obs();
      exp_t o;
      o = '{round_o, data_sel_o, en_reg_state_o, busy_o, done_o};
      return o;
   endfunction

   // One clock: sample just after the edge and score it.
   task automatic cycle();
      exp_t e;
      @(posedge clock_i);
      #1;
      cyc++;
      if (en_reg_state_o === 1'b1) en_cnt++;
      if (done_o === 1'b1) done_cnt++;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = '{idle_round, 1'b0, 1'b0, 1'b0, 1'b0};
      check("trace", 32'(obs()), 32'(e));
   endtask

   task automatic push_run(input logic m);
      logic [3:0] r;
      r = m ? 4'd6 : 4'd0;
      sb_q.push_back('{r, 1'b0, 1'b1, 1'b1, 1'b0});
      for (int k = int'(r) + 1; k <= 11; k++)
         sb_q.push_back('{4'(k), 1'b1, 1'b1, 1'b1, 1'b0});
      sb_q.push_back('{4'd11, 1'b1, 1'b0, 1'b1, 1'b1});
      idle_round = 4'd11;
   endtask

   // Present start for one edge, then flip mode to show it is ignored.
   task automatic start_run(input logic m);
      mode_i  = m;
      start_i = 1'b1;
      push_run(m);
      t0 = cyc;
      cycle();
      start_i = 1'b0;
      mode_i  = ~m;
   endtask

   task automatic wait_done(input string tag, input int lat);
      while (done_o !== 1'b1 && (cyc - t0) < 40) cycle();
      check(tag, 32'(cyc - t0), 32'(lat));
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      cyc        = 0;
      t0         = 0;
      en_cnt     = 0;
      done_cnt   = 0;
      idle_round = 4'd0;
      resetb_i   = 1'b0;
      start_i    = 1'b0;
      mode_i     = 1'b0;

      repeat (2) @(posedge clock_i);
      #1;
      check("reset_state", 32'(obs()), 32'h0);
      @(negedge clock_i);
      resetb_i = 1'b1;
      repeat (2) cycle();

      // p^a: 12 rounds, done 13 cycles after the start edge.
      start_run(1'b0);
      wait_done("pa_latency", 13);
      repeat (2) cycle();

      // p^b: rounds 6..11, done at cycle 7, six enabled cycles.
      en_cnt = 0;
      start_run(1'b1);
      wait_done("pb_latency", 7);
      check("pb_en_cycles", 32'(en_cnt), 32'd6);
      repeat (2) cycle();

      // Start pulse during RUN of p^a must be ignored.
      done_cnt = 0;
      start_run(1'b0);
      repeat (4) cycle();
      start_i = 1'b1;
      mode_i  = 1'b1;
      cycle();
      start_i = 1'b0;
      wait_done("ignored_latency", 13);
      repeat (4) cycle();
      check("ignored_done_cnt", 32'(done_cnt), 32'd1);
      check("ignored_busy", 32'(busy_o), 32'd0);

      // Back-to-back: start held through DONE goes straight to FIRST.
      start_run(1'b0);
      wait_done("b2b_first_latency", 13);
      mode_i  = 1'b1;
      start_i = 1'b1;
      push_run(1'b1);
      t0 = cyc;
      cycle();
      start_i = 1'b0;
      check("b2b_round", 32'(round_o), 32'd6);
      check("b2b_busy", 32'(busy_o), 32'd1);
      wait_done("b2b_pb_latency", 7);
      repeat (2) cycle();

      // Asynchronous reset while round 5 is on the bus.
      start_run(1'b0);
      while (round_o !== 4'd5 && (cyc - t0) < 40) cycle();
      check("rst_reach_r5", 32'(round_o), 32'd5);
      #2;
      resetb_i = 1'b0;
      #1;
      check("async_rst_out", 32'(obs()), 32'h0);
      sb_q.delete();
      idle_round = 4'd0;
      @(negedge clock_i);
      resetb_i = 1'b1;
      done_cnt = 0;
      repeat (16) cycle();
      check("rst_no_done", 32'(done_cnt), 32'd0);

      // Fresh p^a run after the reset.
      start_run(1'b0);
      wait_done("post_rst_latency", 13);

      // Idle stability: datapath register never enabled.
      en_cnt = 0;
      repeat (20) cycle();
      check("idle_en_cnt", 32'(en_cnt), 32'd0);
      check("idle_round", 32'(round_o), 32'd11);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
